// File: rtl/addsub_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// Holds the FSM state encoding, the default operand width and a helper
// that sizes the bit counter from a datapath width.
package addsub_pkg;

  localparam int ADDSUB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } addsub_state_e;

  // A width of 2 still needs a 1-bit counter, so clamp at 1.
  function automatic int addsub_cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder1b.sv
// One-bit full adder: the per-cycle slice of the bit-serial datapath.
// Latency: purely combinational. Backpressure: none.
// Ports: a, b, cin -> s (sum bit), cout (carry out).
module full_adder1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub4b.sv
// Bit-serial WIDTH-bit adder/subtractor, one result bit per clock.
// Latency: o_Valid rises WIDTH edges after the accept edge; WIDTH+2 cycles per op back-to-back.
// Backpressure: result (S/C/V) held stable in DONE until SerAddSub_i_Ready; no request accepted meanwhile.
// Ports: Clk/nRst (sync, active-low); request Valid/Ready with A, B, fSub;
//        response Valid/Ready with S (result), C (raw carry-out), V (signed overflow).
module serial_addsub4b
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic             SerAddSub_i_Clk,
  input  logic             SerAddSub_i_nRst,
  input  logic             SerAddSub_i_Valid,
  output logic             SerAddSub_o_Ready,
  input  logic [WIDTH-1:0] SerAddSub_i_A,
  input  logic [WIDTH-1:0] SerAddSub_i_B,
  input  logic             SerAddSub_i_fSub,
  output logic             SerAddSub_o_Valid,
  input  logic             SerAddSub_i_Ready,
  output logic [WIDTH-1:0] SerAddSub_o_S,
  output logic             SerAddSub_o_C,
  output logic             SerAddSub_o_V
);

  localparam int CNT_W = addsub_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  addsub_state_e    state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  logic fa_s;
  logic fa_cout;

  full_adder1b u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    v_d     = v_q;

    case (state_q)
      ST_IDLE: begin
        if (SerAddSub_i_Valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with fSub.
          a_d     = SerAddSub_i_A;
          b_d     = SerAddSub_i_B ^ {WIDTH{SerAddSub_i_fSub}};
          carry_d = SerAddSub_i_fSub;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Result bits enter from the MSB side so after WIDTH shifts bit 0 sits at s_q[0].
        s_d     = {fa_s, s_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB on this cycle.
          c_d     = fa_cout;
          v_d     = carry_q ^ fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (SerAddSub_i_Ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge SerAddSub_i_Clk) begin
    if (!SerAddSub_i_nRst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  // Gated with reset so a request is never handshaken on a reset edge.
  assign SerAddSub_o_Ready = (state_q == ST_IDLE) && SerAddSub_i_nRst;
  assign SerAddSub_o_Valid = (state_q == ST_DONE);
  assign SerAddSub_o_S     = s_q;
  assign SerAddSub_o_C     = c_q;
  assign SerAddSub_o_V     = v_q;

endmodule
